// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered EX-stage ALU with iterative unsigned multiply/divide
//
// Purpose:
//   Single-cycle operations return one cycle after acceptance at full throughput.
//   MULTU and DIVU iterate one bit per cycle for WIDTH cycles; in_ready stays low
//   while they run, so upstream stalls by holding in_valid.
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-high reset
//   in_valid    entr1/entr2/alu_ctrl valid this cycle
//   in_ready    block accepts an operation this cycle
//   entr1       operand A (also the value shifted by SLL/SRL/SRA)
//   entr2       operand B (low $clog2(WIDTH) bits are the shift amount)
//   alu_ctrl    4-bit operation code
//   out_valid   one-cycle pulse: result outputs are new this cycle
//   alu_result  main result (LO half for MULTU, quotient for DIVU)
//   alu_hi      HI half of product or remainder; 0 for all other ops
//   zero        branch/zero flag
//   overflow    signed overflow for ADD/SUB, 0 otherwise

module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] entr1,
  input  logic [WIDTH-1:0] entr2,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] alu_hi,
  output logic             zero,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_NOR   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_BNE   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_XOR   = 4'b1001;
  localparam logic [3:0] OP_SLL   = 4'b1010;
  localparam logic [3:0] OP_SRL   = 4'b1011;
  localparam logic [3:0] OP_SRA   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_BGEZ  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_hi_out;
  logic             r_zero;
  logic             r_overflow;

  // Iteration datapath, shared by multiply and divide:
  //   MUL: r_hi = running upper product, r_lo = multiplier shifting out / lower product
  //   DIV: r_hi = partial remainder,     r_lo = dividend shifting out / quotient
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opb;

  logic             w_accept;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_is_branch;
  logic             w_branch_zero;
  logic             w_zero_s;
  logic             w_ovf_s;

  logic [WIDTH:0]   w_madd;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_quo;
  logic [CW-1:0]    w_cnt_next;
  logic             w_last;

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign alu_result = r_result;
  assign alu_hi     = r_hi_out;
  assign zero       = r_zero;
  assign overflow   = r_overflow;

  assign w_accept = in_valid && r_in_ready;

  // Single-cycle result, evaluated straight from the input operands
  always_comb begin
    w_shamt       = entr2[SHW-1:0];
    w_sum         = entr1 + entr2;
    w_diff        = entr1 - entr2;
    w_res         = '0;
    w_is_branch   = 1'b0;
    w_branch_zero = 1'b0;
    w_ovf_s       = 1'b0;
    case (alu_ctrl)
      OP_ADD: begin
        w_res   = w_sum;
        w_ovf_s = (entr1[MSB] == entr2[MSB]) && (w_sum[MSB] != entr1[MSB]);
      end
      OP_SUB: begin
        w_res   = w_diff;
        w_ovf_s = (entr1[MSB] != entr2[MSB]) && (w_diff[MSB] != entr1[MSB]);
      end
      OP_AND:  w_res = entr1 & entr2;
      OP_NOR:  w_res = ~(entr1 | entr2);
      OP_OR:   w_res = entr1 | entr2;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(entr1) < $signed(entr2))};
      OP_BEQ: begin
        w_res         = w_diff;
        w_is_branch   = 1'b1;
        w_branch_zero = (entr1 == entr2);
      end
      OP_BNE: begin
        w_res         = w_diff;
        w_is_branch   = 1'b1;
        w_branch_zero = (entr1 != entr2);
      end
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (entr1 < entr2)};
      OP_XOR:  w_res = entr1 ^ entr2;
      OP_SLL:  w_res = entr1 << w_shamt;
      OP_SRL:  w_res = entr1 >> w_shamt;
      OP_SRA:  w_res = $signed(entr1) >>> w_shamt;
      OP_BGEZ: begin
        w_res         = entr1;
        w_is_branch   = 1'b1;
        w_branch_zero = ~entr1[MSB];
      end
      default: w_res = '0;  // MULTU/DIVU results come from the iteration path
    endcase
    w_zero_s = w_is_branch ? w_branch_zero : (w_res == '0);
  end

  // One multiply step: conditionally add multiplicand into the upper half,
  // then shift the whole {hi, lo} pair right by one with the carry.
  assign w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
  assign w_mul_hi = w_madd[WIDTH:1];
  assign w_mul_lo = {w_madd[0], r_lo[WIDTH-1:1]};

  // One restoring divide step: bring down the next dividend bit and keep the
  // subtraction only when it does not borrow. A zero divisor never borrows,
  // which naturally yields quotient all-ones and remainder equal to the dividend.
  assign w_trial   = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_opb};
  assign w_qbit    = ~w_trial[WIDTH];
  assign w_div_rem = w_qbit ? w_trial[WIDTH-1:0] : {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_div_quo = {r_lo[WIDTH-2:0], w_qbit};

  assign w_cnt_next = r_cnt + 1'b1;
  assign w_last     = (w_cnt_next == CW'(WIDTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_hi_out    <= '0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opb       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (alu_ctrl == OP_MULTU || alu_ctrl == OP_DIVU) begin
              r_state    <= (alu_ctrl == OP_MULTU) ? S_MUL : S_DIV;
              r_in_ready <= 1'b0;
              r_cnt      <= '0;
              r_hi       <= '0;
              r_lo       <= entr1;
              r_opb      <= entr2;
            end else begin
              r_out_valid <= 1'b1;
              r_result    <= w_res;
              r_hi_out    <= '0;
              r_zero      <= w_zero_s;
              r_overflow  <= w_ovf_s;
            end
          end
        end
        S_MUL: begin
          r_cnt <= w_cnt_next;
          r_hi  <= w_mul_hi;
          r_lo  <= w_mul_lo;
          if (w_last) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b1;
            r_result    <= w_mul_lo;
            r_hi_out    <= w_mul_hi;
            r_zero      <= (w_mul_lo == '0) && (w_mul_hi == '0);
            r_overflow  <= 1'b0;
          end
        end
        S_DIV: begin
          r_cnt <= w_cnt_next;
          r_hi  <= w_div_rem;
          r_lo  <= w_div_quo;
          if (w_last) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b1;
            r_result    <= w_div_quo;
            r_hi_out    <= w_div_rem;
            r_zero      <= (w_div_quo == '0);
            r_overflow  <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe (WIDTH=32)
//
// Purpose:
//   Directed vectors with hand-computed results, plus a transaction-level
//   model (plain integer arithmetic and a busy countdown) compared against
//   the DUT outputs on every falling edge.
//
// Ports: none (top-level bench).

module tb_alu_pipe;

  localparam int WIDTH = 32;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, NOR_ = 4'd3, OR_ = 4'd4;
  localparam logic [3:0] SLT = 4'd5, BEQ = 4'd6, BNE = 4'd7, SLTU = 4'd8, XOR_ = 4'd9;
  localparam logic [3:0] SLL = 4'd10, SRL = 4'd11, SRA = 4'd12, MULTU = 4'd13;
  localparam logic [3:0] DIVU = 4'd14, BGEZ = 4'd15;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] entr1;
  logic [WIDTH-1:0] entr2;
  logic [3:0]       alu_ctrl;
  logic             out_valid;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] alu_hi;
  logic             zero;
  logic             overflow;

  int errors = 0;
  int checks = 0;

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .entr1(entr1), .entr2(entr2), .alu_ctrl(alu_ctrl), .out_valid(out_valid),
    .alu_result(alu_result), .alu_hi(alu_hi), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  function automatic void model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic [31:0] h,
                                   output logic z, output logic v);
    longint      s;
    logic [63:0] p;
    r = 32'd0; h = 32'd0; v = 1'b0;
    case (op)
      ADD: begin
        r = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        v = (s >= (64'sd1 <<< 31)) || (s < -(64'sd1 <<< 31));
      end
      SUB: begin
        r = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        v = (s >= (64'sd1 <<< 31)) || (s < -(64'sd1 <<< 31));
      end
      AND_: r = a & b;
      NOR_: r = ~(a | b);
      OR_:  r = a | b;
      SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      BEQ, BNE: r = a - b;
      SLTU: r = (a < b) ? 32'd1 : 32'd0;
      XOR_: r = a ^ b;
      SLL:  r = a << b[4:0];
      SRL:  r = a >> b[4:0];
      SRA:  r = $signed(a) >>> b[4:0];
      MULTU: begin
        p = 64'(a) * 64'(b);
        r = p[31:0];
        h = p[63:32];
      end
      DIVU: begin
        if (b == 32'd0) begin r = 32'hFFFFFFFF; h = a; end
        else begin r = a / b; h = a % b; end
      end
      default: r = a;  // BGEZ
    endcase
    case (op)
      BEQ:     z = (a == b);
      BNE:     z = (a != b);
      BGEZ:    z = ($signed(a) >= 0);
      MULTU:   z = (r == 32'd0) && (h == 32'd0);
      default: z = (r == 32'd0);
    endcase
  endfunction

  logic        m_ready = 1'b1;
  logic        m_valid = 1'b0;
  int          m_wait  = 0;
  logic [31:0] e_res = '0, e_hi = '0, p_res = '0, p_hi = '0;
  logic        e_z = 1'b0, e_v = 1'b0, p_z = 1'b0;

  always @(posedge clk or posedge reset) begin
    logic [31:0] r, h;
    logic        z, v;
    if (reset) begin
      m_ready = 1'b1; m_valid = 1'b0; m_wait = 0;
      e_res = '0; e_hi = '0; e_z = 1'b0; e_v = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (!m_ready) begin
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
          m_ready = 1'b1; m_valid = 1'b1;
          e_res = p_res; e_hi = p_hi; e_z = p_z; e_v = 1'b0;
        end
      end else if (in_valid) begin
        model_op(alu_ctrl, entr1, entr2, r, h, z, v);
        if (alu_ctrl == MULTU || alu_ctrl == DIVU) begin
          m_ready = 1'b0; m_wait = WIDTH;
          p_res = r; p_hi = h; p_z = z;
        end else begin
          m_valid = 1'b1;
          e_res = r; e_hi = h; e_z = z; e_v = v;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    checks++;
    if (out_valid !== m_valid) begin
      errors++;
      $display("FAIL out_valid @%0t: got %b expected %b", $time, out_valid, m_valid);
    end
    checks++;
    if (in_ready !== m_ready) begin
      errors++;
      $display("FAIL in_ready @%0t: got %b expected %b", $time, in_ready, m_ready);
    end
    checks++;
    if ({alu_result, alu_hi, zero, overflow} !== {e_res, e_hi, e_z, e_v}) begin
      errors++;
      $display("FAIL outputs @%0t: got res=%h hi=%h z=%b v=%b expected res=%h hi=%h z=%b v=%b",
               $time, alu_result, alu_hi, zero, overflow, e_res, e_hi, e_z, e_v);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Present an op at the current falling edge and hold it until accepted;
  // returns at the falling edge of the first cycle after acceptance.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_valid = 1'b1; alu_ctrl = op; entr1 = a; entr2 = b;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=%b expected 1 within 100 cycles", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for out_valid; lat counts cycles since acceptance (1 = next cycle).
  task automatic get_result(output int lat, output int low);
    lat = 1; low = 0;
    while (1) begin
      if (!in_ready) low++;
      if (out_valid) break;
      if (lat >= 200) begin
        checks++; errors++;
        $display("FAIL result_timeout: got no out_valid expected one within 200 cycles");
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run1(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] x_res, input logic x_z);
    int lat, low;
    send(op, a, b);
    get_result(lat, low);
    chk({name, "_lat"}, lat, 1);
    chk({name, "_res"}, alu_result, x_res);
    chk({name, "_zero"}, 32'(zero), 32'(x_z));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, low, pulses;
    logic [31:0] r, h;
    logic z, v;

    reset = 1'b1; in_valid = 1'b0; alu_ctrl = 4'd0; entr1 = '0; entr2 = '0;

    // Pin the model against a few hand-computed values
    model_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, r, h, z, v);
    chk("model_multu_hi", h, 32'hFFFFFFFE);
    chk("model_multu_lo", r, 32'h00000001);
    model_op(ADD, 32'h7FFFFFFF, 32'h1, r, h, z, v);
    chk("model_add_ovf", 32'(v), 32'd1);
    model_op(SUB, 32'h80000000, 32'h1, r, h, z, v);
    chk("model_sub_ovf", {r[30:0], v}, {31'h7FFFFFFF, 1'b1});

    repeat (3) @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_result", alu_result, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // ADD overflow, then SUB back-to-back
    run1("add_ovf", ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0);
    chk("add_ovf_flag", 32'(overflow), 32'd1);
    run1("sub_eq", SUB, 32'd5, 32'd5, 32'd0, 1'b1);
    chk("sub_eq_flag", 32'(overflow), 32'd0);

    // Compares and shifts
    run1("slt", SLT, 32'hFFFFFFFF, 32'h1, 32'd1, 1'b0);
    run1("sltu", SLTU, 32'hFFFFFFFF, 32'h1, 32'd0, 1'b1);
    run1("sra", SRA, 32'h80000000, 32'd4, 32'hF8000000, 1'b0);
    run1("sll", SLL, 32'h1, 32'd31, 32'h80000000, 1'b0);

    // Four branches on consecutive cycles
    pulses = 0;
    send(BEQ, 32'd5, 32'd5);  get_result(lat, low); if (lat == 1) pulses++;
    chk("beq_zero", 32'(zero), 32'd1);
    send(BNE, 32'd5, 32'd5);  get_result(lat, low); if (lat == 1) pulses++;
    chk("bne_zero", 32'(zero), 32'd0);
    send(BGEZ, 32'hFFFFFFFF, 32'd0); get_result(lat, low); if (lat == 1) pulses++;
    chk("bgez_neg_zero", 32'(zero), 32'd0);
    send(BGEZ, 32'd0, 32'd0); get_result(lat, low); if (lat == 1) pulses++;
    chk("bgez_0_zero", 32'(zero), 32'd1);
    chk("branch_pulses", pulses, 4);

    // Remaining logic ops and overflow corners, checked by the model
    send(AND_, 32'hF0F0_1234, 32'h0FF0_FFFF);
    send(NOR_, 32'h0000_00FF, 32'hFF00_0000);
    send(OR_,  32'h1200_0000, 32'h0034_0056);
    send(XOR_, 32'hAAAA_5555, 32'hFFFF_0000);
    send(SRL,  32'h8000_0000, 32'd31);
    send(SRA,  32'h8000_0001, 32'd0);
    send(ADD,  32'h8000_0000, 32'h8000_0000);
    send(SUB,  32'h8000_0000, 32'h0000_0001);
    send(SUB,  32'h7FFF_FFFF, 32'hFFFF_FFFF);
    chk("sub_ovf_res", alu_result, 32'h80000000);
    chk("sub_ovf_flag", 32'(overflow), 32'd1);

    // MULTU with another op held pending throughout
    send(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    in_valid = 1'b1; alu_ctrl = ADD; entr1 = 32'd2; entr2 = 32'd3;
    get_result(lat, low);
    chk("multu_lat", lat, 33);
    chk("multu_ready_low", low, 32);
    chk("multu_hi", alu_hi, 32'hFFFFFFFE);
    chk("multu_lo", alu_result, 32'h00000001);
    @(negedge clk);
    in_valid = 1'b0;
    chk("held_add_valid", 32'(out_valid), 32'd1);
    chk("held_add_res", alu_result, 32'd5);

    send(MULTU, 32'd12345, 32'd6789); get_result(lat, low);
    chk("multu_small", alu_result, 32'd83810205);

    // DIVU
    send(DIVU, 32'd100, 32'd7); get_result(lat, low);
    chk("divu_lat", lat, 33);
    chk("divu_q", alu_result, 32'd14);
    chk("divu_r", alu_hi, 32'd2);
    send(DIVU, 32'd100, 32'd0); get_result(lat, low);
    chk("div0_lat", lat, 33);
    chk("div0_q", alu_result, 32'hFFFFFFFF);
    chk("div0_r", alu_hi, 32'd100);
    send(DIVU, 32'hFFFFFFFF, 32'd1); get_result(lat, low);

    // Reset in iteration cycle 10 of a MULTU
    send(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_ready", 32'(in_ready), 32'd1);
    chk("rst_async_outs", {alu_result[30:0], zero}, 32'd0);
    chk("rst_async_hi", alu_hi, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", 32'(in_ready), 32'd1);
    pulses = 0;
    repeat (40) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    chk("rst_no_valid", pulses, 0);
    run1("post_rst_add", ADD, 32'd2, 32'd3, 32'd5, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
